ecc_host_loader: RTL and testbench
==================================

Name: ecc_host_loader

Overview:
- Host-side sequencer directly upstream of the banked operand RAM interface. It drives that interface's port A: a_w, 6-bit a_adbus, and 256-bit a_data_in/a_data_out.
- Assembles 32-bit host beats into 256-bit operands and writes them to RAM banks A-D. Also reads 256-bit results back as 32-bit beats and writes the 4-bit command register.
- All RAM traffic goes through one FSM, so port A sees at most one access in flight.

Parameters:
- DATA, 256, operand width on the RAM side.
- WORD, 32, host beat width; DATA/WORD = 8 beats per operand.
- ADDR, 6, RAM port-A address width: [5:3] = bank, [2:0] = word.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_start  in  1  one-cycle request to load an operand.
- ld_addr  in  6  target address of the load.
- rd_start  in  1  one-cycle request to read an operand back.
- rd_addr  in  6  source address of the read.
- cmd_start  in  1  one-cycle request to write the command register.
- cmd_val  in  4  command value to write.
- s_valid  in  1  host write beat valid.
- s_ready  out  1  block accepts a host write beat.
- s_data  in  WORD  host write beat, least-significant word first.
- m_valid  out  1  read beat valid.
- m_ready  in  1  host accepts the read beat.
- m_data  out  WORD  read beat, least-significant word first.
- a_w  out  1  port-A write strobe.
- a_adbus  out  ADDR  port-A address.
- a_data_in  out  DATA  port-A write data.
- a_data_out  in  DATA  port-A read data.
- busy  out  1  FSM is not in IDLE.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; shift register and beat counter clear.
  - All outputs are 0: a_w, a_adbus, a_data_in, s_ready, m_valid, m_data, busy, err.
  - Reset in any state aborts the operation and discards partial data; no RAM write is issued.
- Address legality:
  - Operand addresses are legal only for bank [5:3] in {001, 010, 011, 100}.
  - Any other bank on ld_start or rd_start: err pulses for 1 cycle, FSM stays IDLE, no RAM access.
- Request handling:
  - Requests are sampled only in IDLE; requests arriving while busy are ignored silently (no err).
  - Priority for simultaneous requests: cmd_start > ld_start > rd_start. Lower-priority requests are dropped.
- States and transitions:
  - IDLE: s_ready = 0, m_valid = 0, a_w = 0.
  - CMD_WR (1 cycle): a_w = 1, a_adbus = 6'd1, a_data_in = {252'b0, cmd_val latched}. Then IDLE.
  - LOAD: s_ready = 1. Each s_valid && s_ready beat shifts s_data into bits [WORD*k +: WORD], k = 0..7. The 3-bit beat counter wraps 7 -> 0 and moves the FSM to WRITE. No timeout; the host may stall indefinitely.
  - WRITE (1 cycle): a_w = 1, a_adbus = latched ld_addr, a_data_in = assembled operand. Then IDLE.
  - RD_ADDR (1 cycle): a_w = 0, a_adbus = latched rd_addr.
  - RD_WAIT (1 cycle): a_adbus held. a_data_out is captured at the end of this cycle, giving 1-cycle synchronous-read latency.
  - RD_STREAM: m_valid = 1, m_data = word k of the captured operand.
    - m_data is held stable until m_valid && m_ready.
    - After word 7 is accepted, go to IDLE.
- Bus idle values: outside CMD_WR/WRITE/RD_*, a_adbus = 0 and a_data_in = 0, so the RAM side never sees X or Z.
- Timing:
  - Load latency: last beat accepted -> a_w high on the next cycle.
  - Command latency: cmd_start -> a_w high on the next cycle.
  - Read latency: rd_start -> first m_valid 3 cycles later.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package ecc_ram_pkg holds:
  - Bank codes BANK_A..BANK_D = 3'b001..3'b100.
  - CMD_ADDR = 6'd1.
  - BEATS = DATA/WORD.
  - State enumeration.
- One natural sub-module, ecc_word_gearbox: a WORD<->DATA shift register with beat counter, used for both assembly and streaming.
- The FSM stays in ecc_host_loader.

Test Plan:
- Load: ld_start with ld_addr = 6'o12; 8 beats 32'h0000_0001..32'h0000_0008, one per cycle -> one a_w pulse with a_adbus = 6'o12 and a_data_in = {32'h8, ..., 32'h1}.
- Read-back: preload RAM address 6'o21 with 256'h1; rd_start with rd_addr = 6'o21 -> m_valid 3 cycles later with beats 32'h1, 0, 0, 0, 0, 0, 0, 0. With m_ready toggling 1/0, m_data holds while m_ready = 0.
- Command plus simultaneous requests: cmd_start with cmd_val = 4'hA together with ld_start -> a_adbus = 6'd1, a_data_in[3:0] = 4'hA; LOAD is not entered.
- Illegal address: ld_start with ld_addr = 6'o52 (bank 101) -> err pulses for 1 cycle, busy stays 0, a_w stays 0.
- Reset mid-load: assert rst after 5 beats -> outputs go to 0 immediately. A fresh 8-beat load then writes only the new data, with no a_w during the aborted sequence.
- Stalled host: s_valid gaps of 10 cycles between beats -> exactly one write, issued after beat 8.

Source files
------------

// File: rtl/ecc_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ecc_ram_pkg
//  Purpose  : Shared constants, bank codes, FSM state type and address
//             legality helper for the banked operand RAM host loader.
//  Contents : DATA_W / WORD_W / ADDR_W default widths, BEATS per operand,
//             BANK_A..BANK_D codes, CMD_ADDR, state_t, bank_is_legal().
//  Revision : 1.0 - initial release
// ============================================================================
package ecc_ram_pkg;

  localparam int DATA_W = 256;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 6;
  localparam int BEATS  = DATA_W / WORD_W;

  // Operand banks live in address bits [5:3]
  localparam logic [2:0] BANK_A = 3'b001;
  localparam logic [2:0] BANK_B = 3'b010;
  localparam logic [2:0] BANK_C = 3'b011;
  localparam logic [2:0] BANK_D = 3'b100;

  // Command register location on port A
  localparam logic [ADDR_W-1:0] CMD_ADDR = 6'd1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD_WR    = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RD_ADDR   = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_RD_STREAM = 3'd6
  } state_t;

  // Only the four operand banks may be loaded or read back
  function automatic logic bank_is_legal(input logic [2:0] bank);
    logic legal;
    case (bank)
      BANK_A, BANK_B, BANK_C, BANK_D: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage : ecc_ram_pkg
`default_nettype wire

// File: rtl/ecc_word_gearbox.sv
`default_nettype none
// ============================================================================
//  Module   : ecc_word_gearbox
//  Purpose  : WORD <-> DATA shift register with a beat counter. Shifting
//             inserts shift_in at the top and drops the bottom word, so after
//             BEATS shifts the first word sits in bits [WORD-1:0]. The same
//             register streams a parallel-loaded operand out LSW first.
//  Ports    : clk, rst       - clock, async active-high reset
//             load_en        - parallel load of load_data, counter to 0
//             load_data      - DATA-wide parallel value
//             shift_en       - shift one word, advance counter (wraps)
//             shift_in       - word entering at the top
//             data_q         - current register contents
//             shift_data     - value the register takes on a shift
//             last_beat      - counter is on the final beat of an operand
//  Revision : 1.0 - initial release
// ============================================================================
module ecc_word_gearbox #(
  parameter int DATA = 256,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [DATA-1:0] load_data,
  input  logic            shift_en,
  input  logic [WORD-1:0] shift_in,
  output logic [DATA-1:0] data_q,
  output logic [DATA-1:0] shift_data,
  output logic            last_beat
);

  localparam int BEATS = DATA / WORD;
  localparam int CNT_W = $clog2(BEATS);

  logic [DATA-1:0]  data_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign shift_data = {shift_in, data_q[DATA-1:WORD]};
  assign last_beat  = (count_q == CNT_W'(BEATS - 1));

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (load_en) begin
      data_d  = load_data;
      count_d = '0;
    end else if (shift_en) begin
      data_d  = shift_data;
      // Natural wrap of the counter returns it to 0 after the final beat
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule : ecc_word_gearbox
`default_nettype wire

// File: rtl/ecc_host_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ecc_host_loader
//  Purpose  : Host-side sequencer for port A of the banked operand RAM.
//             Assembles 32-bit host beats into 256-bit operands and writes
//             them, reads operands back as 32-bit beats, and writes the
//             4-bit command register. A single FSM owns port A, so at most
//             one access is ever in flight.
//  Ports    : clk, rst                  - clock, async active-high reset
//             ld_start/ld_addr          - operand load request
//             rd_start/rd_addr          - operand read-back request
//             cmd_start/cmd_val         - command register write request
//             s_valid/s_ready/s_data    - host write beats (LSW first)
//             m_valid/m_ready/m_data    - read beats to host (LSW first)
//             a_w/a_adbus/a_data_in     - RAM port-A write strobe/addr/data
//             a_data_out                - RAM port-A read data (1-cycle)
//             busy                      - FSM not idle
//             err                       - one-cycle rejected-request pulse
//  Revision : 1.0 - initial release
// ============================================================================
module ecc_host_loader
  import ecc_ram_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int WORD = WORD_W,
  parameter int ADDR = ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_start,
  input  logic [ADDR-1:0] ld_addr,
  input  logic            rd_start,
  input  logic [ADDR-1:0] rd_addr,
  input  logic            cmd_start,
  input  logic [3:0]      cmd_val,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [WORD-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [WORD-1:0] m_data,
  output logic            a_w,
  output logic [ADDR-1:0] a_adbus,
  output logic [DATA-1:0] a_data_in,
  input  logic [DATA-1:0] a_data_out,
  output logic            busy,
  output logic            err
);

  state_t          state_q,     state_d;
  logic [ADDR-1:0] addr_q,      addr_d;
  logic            a_w_q,       a_w_d;
  logic [ADDR-1:0] a_adbus_q,   a_adbus_d;
  logic [DATA-1:0] a_data_in_q, a_data_in_d;
  logic            s_ready_q,   s_ready_d;
  logic            m_valid_q,   m_valid_d;
  logic [WORD-1:0] m_data_q,    m_data_d;
  logic            busy_q,      busy_d;
  logic            err_q,       err_d;

  logic            gb_load;
  logic            gb_shift;
  logic [WORD-1:0] gb_shift_in;
  logic [DATA-1:0] gb_data;
  logic [DATA-1:0] gb_shift_data;
  logic            gb_last;

  // Zero enters the top while streaming so stale words never reappear
  assign gb_shift_in = (state_q == ST_LOAD) ? s_data : '0;

  ecc_word_gearbox #(
    .DATA (DATA),
    .WORD (WORD)
  ) u_gearbox (
    .clk        (clk),
    .rst        (rst),
    .load_en    (gb_load),
    .load_data  (a_data_out),
    .shift_en   (gb_shift),
    .shift_in   (gb_shift_in),
    .data_q     (gb_data),
    .shift_data (gb_shift_data),
    .last_beat  (gb_last)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    a_w_d       = 1'b0;
    a_adbus_d   = '0;
    a_data_in_d = '0;
    s_ready_d   = 1'b0;
    m_valid_d   = 1'b0;
    m_data_d    = '0;
    err_d       = 1'b0;
    gb_load     = 1'b0;
    gb_shift    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Fixed priority: command, then load, then read
        if (cmd_start) begin
          state_d     = ST_CMD_WR;
          a_w_d       = 1'b1;
          a_adbus_d   = CMD_ADDR;
          a_data_in_d = {{(DATA-4){1'b0}}, cmd_val};
        end else if (ld_start) begin
          if (bank_is_legal(ld_addr[ADDR-1 -: 3])) begin
            state_d   = ST_LOAD;
            addr_d    = ld_addr;
            s_ready_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (rd_start) begin
          if (bank_is_legal(rd_addr[ADDR-1 -: 3])) begin
            state_d   = ST_RD_ADDR;
            addr_d    = rd_addr;
            a_adbus_d = rd_addr;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_CMD_WR: state_d = ST_IDLE;

      ST_LOAD: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          gb_shift = 1'b1;
          if (gb_last) begin
            // Final beat: the write carries the register's post-shift value
            state_d     = ST_WRITE;
            s_ready_d   = 1'b0;
            a_w_d       = 1'b1;
            a_adbus_d   = addr_q;
            a_data_in_d = gb_shift_data;
          end
        end
      end

      ST_WRITE: state_d = ST_IDLE;

      ST_RD_ADDR: begin
        state_d   = ST_RD_WAIT;
        a_adbus_d = addr_q;
      end

      ST_RD_WAIT: begin
        // RAM output is valid now; capture it and present word 0
        state_d   = ST_RD_STREAM;
        gb_load   = 1'b1;
        m_valid_d = 1'b1;
        m_data_d  = a_data_out[WORD-1:0];
      end

      ST_RD_STREAM: begin
        m_valid_d = 1'b1;
        m_data_d  = m_data_q;
        if (m_valid_q && m_ready) begin
          gb_shift = 1'b1;
          if (gb_last) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_data_d  = '0;
          end else begin
            m_data_d = gb_shift_data[WORD-1:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      a_w_q       <= 1'b0;
      a_adbus_q   <= '0;
      a_data_in_q <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      a_w_q       <= a_w_d;
      a_adbus_q   <= a_adbus_d;
      a_data_in_q <= a_data_in_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign a_w       = a_w_q;
  assign a_adbus   = a_adbus_q;
  assign a_data_in = a_data_in_q;
  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule : ecc_host_loader
`default_nettype wire

// File: tb/tb_ecc_host_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ecc_host_loader
//  Purpose  : Directed self-checking bench for ecc_host_loader with a
//             behavioural 1-cycle synchronous-read RAM on port A.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_host_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_start, rd_start, cmd_start;
  logic [5:0]   ld_addr, rd_addr;
  logic [3:0]   cmd_val;
  logic         s_valid, s_ready;
  logic [31:0]  s_data;
  logic         m_valid, m_ready;
  logic [31:0]  m_data;
  logic         a_w;
  logic [5:0]   a_adbus;
  logic [255:0] a_data_in, a_data_out;
  logic         busy, err;

  // Bench-side preload port into the RAM model
  logic         pre_en;
  logic [5:0]   pre_addr;
  logic [255:0] pre_data;

  logic [255:0] mem [0:63];
  int           wr_cnt = 0;
  logic [5:0]   last_wr_addr;
  logic [255:0] last_wr_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecc_host_loader dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_addr    (ld_addr),
    .rd_start   (rd_start),
    .rd_addr    (rd_addr),
    .cmd_start  (cmd_start),
    .cmd_val    (cmd_val),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .a_w        (a_w),
    .a_adbus    (a_adbus),
    .a_data_in  (a_data_in),
    .a_data_out (a_data_out),
    .busy       (busy),
    .err        (err)
  );

  // RAM model: write-on-strobe, registered read of the presented address
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (a_w) begin
      mem[a_adbus] <= a_data_in;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= a_adbus;
      last_wr_data <= a_data_in;
    end
    a_data_out <= mem[a_adbus];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           base;
  logic [255:0] exp_op;

  initial begin
    rst = 1'b1;
    ld_start = 0; rd_start = 0; cmd_start = 0;
    ld_addr = 0; rd_addr = 0; cmd_val = 0;
    s_valid = 0; s_data = 0; m_ready = 0;
    pre_en = 0; pre_addr = 0; pre_data = 0;
    tick(); tick();

    // ---------------- reset state ----------------
    chk("rst_a_w",      a_w,       0);
    chk("rst_adbus",    a_adbus,   0);
    chk("rst_data_in",  a_data_in, 0);
    chk("rst_s_ready",  s_ready,   0);
    chk("rst_m_valid",  m_valid,   0);
    chk("rst_m_data",   m_data,    0);
    chk("rst_busy",     busy,      0);
    chk("rst_err",      err,       0);
    rst = 1'b0;
    tick();

    // ---------------- load 6'o12 with beats 1..8 ----------------
    base = wr_cnt;
    ld_start = 1; ld_addr = 6'o12;
    tick();
    ld_start = 0;
    chk("ld_s_ready", s_ready, 1);
    chk("ld_busy",    busy,    1);
    for (int k = 1; k <= 8; k++) begin
      s_valid = 1; s_data = 32'(k);
      tick();
      if (k < 8) chk("ld_no_early_w", a_w, 0);
    end
    s_valid = 0;
    exp_op = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    chk("ld_a_w",     a_w,       1);
    chk("ld_adbus",   a_adbus,   6'o12);
    chk("ld_data_in", a_data_in, exp_op);
    chk("ld_s_ready_off", s_ready, 0);
    tick();
    chk("ld_w_done",  a_w,    0);
    chk("ld_idle",    busy,   0);
    chk("ld_adbus_idle", a_adbus, 0);
    chk("ld_wr_cnt",  wr_cnt, base + 1);

    // ---------------- read back 6'o12, m_ready held high ----------------
    m_ready = 1;
    rd_start = 1; rd_addr = 6'o12;
    tick();
    rd_start = 0;
    chk("rd_addr_adbus", a_adbus, 6'o12);
    chk("rd_addr_mv",    m_valid, 0);
    chk("rd_addr_aw",    a_w,     0);
    tick();
    chk("rd_wait_adbus", a_adbus, 6'o12);
    chk("rd_wait_mv",    m_valid, 0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("rd12_mv",   m_valid, 1);
      chk("rd12_data", m_data,  32'(k));
      tick();
    end
    chk("rd12_end_mv",   m_valid, 0);
    chk("rd12_end_busy", busy,    0);

    // ---------------- read 6'o21 preloaded with 1, m_ready toggling ----------------
    m_ready = 0;
    pre_en = 1; pre_addr = 6'o21; pre_data = 256'h1;
    tick();
    pre_en = 0;
    rd_start = 1; rd_addr = 6'o21;
    tick();
    rd_start = 0;
    tick(); tick();
    for (int k = 0; k < 8; k++) begin
      chk("rd21_mv",   m_valid, 1);
      chk("rd21_data", m_data,  (k == 0) ? 32'h1 : 32'h0);
      m_ready = 0;
      tick();
      chk("rd21_hold_mv",   m_valid, 1);
      chk("rd21_hold_data", m_data,  (k == 0) ? 32'h1 : 32'h0);
      m_ready = 1;
      tick();
    end
    m_ready = 0;
    chk("rd21_end_mv", m_valid, 0);
    chk("rd21_end_busy", busy, 0);

    // ---------------- command with simultaneous load ----------------
    base = wr_cnt;
    cmd_start = 1; cmd_val = 4'hA; ld_start = 1; ld_addr = 6'o12;
    tick();
    cmd_start = 0; ld_start = 0;
    chk("cmd_a_w",     a_w,       1);
    chk("cmd_adbus",   a_adbus,   6'd1);
    chk("cmd_data_in", a_data_in, 256'hA);
    chk("cmd_busy",    busy,      1);
    chk("cmd_s_ready", s_ready,   0);
    tick();
    chk("cmd_w_done",  a_w,     0);
    chk("cmd_no_load", s_ready, 0);
    chk("cmd_idle",    busy,    0);
    chk("cmd_wr_cnt",  wr_cnt,  base + 1);

    // ---------------- illegal addresses ----------------
    base = wr_cnt;
    ld_start = 1; ld_addr = 6'o52;
    tick();
    ld_start = 0;
    chk("ill_ld_err",  err,  1);
    chk("ill_ld_busy", busy, 0);
    chk("ill_ld_aw",   a_w,  0);
    tick();
    chk("ill_ld_err_pulse", err, 0);
    rd_start = 1; rd_addr = 6'o02;
    tick();
    rd_start = 0;
    chk("ill_rd_err",  err,  1);
    chk("ill_rd_busy", busy, 0);
    tick();
    chk("ill_rd_err_pulse", err, 0);
    chk("ill_wr_cnt", wr_cnt, base);

    // ---------------- request while busy is ignored silently ----------------
    ld_start = 1; ld_addr = 6'o33;
    tick();
    ld_start = 0;
    rd_start = 1; rd_addr = 6'o77;
    tick();
    rd_start = 0;
    chk("busy_ign_err",   err,     0);
    chk("busy_ign_ready", s_ready, 1);
    // Abort this load via reset below

    // ---------------- reset mid-load ----------------
    base = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1; s_data = 32'hDEAD_0000 + 32'(k);
      tick();
    end
    s_valid = 0;
    rst = 1;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy",    busy,    0);
    chk("midrst_a_w",     a_w,     0);
    tick();
    rst = 0;
    tick();
    chk("midrst_no_write", wr_cnt, base);
    ld_start = 1; ld_addr = 6'o41;
    tick();
    ld_start = 0;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1; s_data = 32'h1000_0000 + 32'(k);
      tick();
    end
    s_valid = 0;
    exp_op = 256'h10000007_10000006_10000005_10000004_10000003_10000002_10000001_10000000;
    chk("fresh_a_w",   a_w,       1);
    chk("fresh_adbus", a_adbus,   6'o41);
    chk("fresh_data",  a_data_in, exp_op);
    tick();
    chk("fresh_wr_cnt", wr_cnt, base + 1);

    // ---------------- stalled host, 10-cycle gaps ----------------
    base = wr_cnt;
    ld_start = 1; ld_addr = 6'o33;
    tick();
    ld_start = 0;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1; s_data = 32'h50 + 32'(k);
      tick();
      s_valid = 0;
      if (k < 7) begin
        repeat (10) tick();
        chk("stall_ready", s_ready, 1);
      end
    end
    chk("stall_no_early", wr_cnt, base);
    exp_op = 256'h00000057_00000056_00000055_00000054_00000053_00000052_00000051_00000050;
    chk("stall_a_w",   a_w,       1);
    chk("stall_data",  a_data_in, exp_op);
    tick();
    repeat (3) tick();
    chk("stall_wr_cnt", wr_cnt, base + 1);
    chk("stall_addr",   last_wr_addr, 6'o33);
    chk("stall_busy",   busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ecc_host_loader
`default_nettype wire
